// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM signal bundle for the memory arbiter
interface mem_arbiter_if;
    // data requester (coherence bus controller)
    logic              bus_dREN;
    logic              bus_dWEN;
    logic [31:0]       bus_daddr;
    logic [31:0]       bus_dstore;
    logic              bus_dwait;
    logic [31:0]       bus_dload;
    // instruction requesters (two icaches)
    logic [1:0]        iREN;
    logic [1:0][31:0]  iaddr;
    logic [1:0]        iwait;
    logic [1:0][31:0]  iload;
    // RAM port
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;

    // arbiter view
    modport slave (
        input  bus_dREN, bus_dWEN, bus_daddr, bus_dstore, iREN, iaddr, ramload, ramstate,
        output bus_dwait, bus_dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    // requester/RAM view
    modport master (
        output bus_dREN, bus_dWEN, bus_daddr, bus_dstore, iREN, iaddr, ramload, ramstate,
        input  bus_dwait, bus_dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single RAM port arbiter: data priority, starvation guard, icache round-robin
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DATA, INSTR0, INSTR1} state_t;

    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    state_t      r_state;
    state_t      w_next;
    state_t      w_instr_tgt;
    logic        r_rr;
    logic [3:0]  r_starve_cnt;
    logic        w_dreq;
    logic        w_any_i;
    logic        w_both_i;
    logic        w_access;

    assign w_dreq   = bus.bus_dREN | bus.bus_dWEN;
    assign w_any_i  = |bus.iREN;
    assign w_both_i = &bus.iREN;
    assign w_access = (bus.ramstate == RAM_ACCESS);

    // read data is a pure pass-through to every requester
    assign bus.bus_dload = bus.ramload;
    assign bus.iload[0]  = bus.ramload;
    assign bus.iload[1]  = bus.ramload;

    // pick which icache wins: round-robin pointer only matters when both ask
    always_comb begin
        w_instr_tgt = INSTR0;
        if (w_both_i)
            w_instr_tgt = r_rr ? INSTR1 : INSTR0;
        else if (bus.iREN[1])
            w_instr_tgt = INSTR1;
    end

    // next-state selection and RAM/wait outputs for the current grant
    always_comb begin
        w_next        = r_state;
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = 32'd0;
        bus.ramstore  = 32'd0;
        bus.bus_dwait = 1'b1;
        bus.iwait     = 2'b11;
        case (r_state)
            IDLE: begin
                if ((r_starve_cnt == LIMIT) && w_any_i)
                    w_next = w_instr_tgt;
                else if (w_dreq)
                    w_next = DATA;
                else if (w_any_i)
                    w_next = w_instr_tgt;
            end
            DATA: begin
                bus.ramaddr = bus.bus_daddr;
                if (bus.bus_dWEN) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramstore = bus.bus_dstore;
                end else begin
                    bus.ramREN = bus.bus_dREN;
                end
                if (!w_dreq) begin
                    w_next = IDLE;
                end else if (w_access) begin
                    bus.bus_dwait = 1'b0;
                    w_next        = IDLE;
                end
            end
            INSTR0: begin
                bus.ramREN  = bus.iREN[0];
                bus.ramaddr = bus.iaddr[0];
                if (!bus.iREN[0]) begin
                    w_next = IDLE;
                end else if (w_access) begin
                    bus.iwait[0] = 1'b0;
                    w_next       = IDLE;
                end
            end
            INSTR1: begin
                bus.ramREN  = bus.iREN[1];
                bus.ramaddr = bus.iaddr[1];
                if (!bus.iREN[1]) begin
                    w_next = IDLE;
                end else if (w_access) begin
                    bus.iwait[1] = 1'b0;
                    w_next       = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // fairness bookkeeping, updated only on the edge that issues a grant
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr         <= 1'b0;
            r_starve_cnt <= 4'd0;
        end else if (r_state == IDLE) begin
            if (w_next == DATA) begin
                if (w_any_i && (r_starve_cnt != LIMIT))
                    r_starve_cnt <= r_starve_cnt + 4'd1;
            end else if ((w_next == INSTR0) || (w_next == INSTR1)) begin
                r_starve_cnt <= 4'd0;
                if (w_both_i)
                    r_rr <= ~r_rr;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_fail;

    mem_arbiter_if u_if ();

    mem_arbiter #(.STARVE_LIMIT(4)) u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (u_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] g_addr [10];
    logic [2:0]  g_wait [10];
    int          n_grant;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nRST           = 1'b0;
        u_if.bus_dREN  = 1'b0;
        u_if.bus_dWEN  = 1'b0;
        u_if.bus_daddr = 32'd0;
        u_if.bus_dstore= 32'd0;
        u_if.iREN      = 2'b00;
        u_if.iaddr[0]  = 32'h100;
        u_if.iaddr[1]  = 32'h300;
        u_if.ramload   = 32'd0;
        u_if.ramstate  = 2'd0;

        // reset state
        #12;
        check_eq("rst_ramREN", 32'(u_if.ramREN), 32'd0);
        check_eq("rst_ramWEN", 32'(u_if.ramWEN), 32'd0);
        check_eq("rst_dwait",  32'(u_if.bus_dwait), 32'd1);
        check_eq("rst_iwait",  32'(u_if.iwait), 32'd3);
        check_eq("rst_ramaddr", u_if.ramaddr, 32'd0);
        step; nRST = 1'b1;

        // single fetch from core 0
        step; u_if.iREN = 2'b01; u_if.ramstate = 2'd1;
        @(negedge CLK); check_eq("t1_latency_ren", 32'(u_if.ramREN), 32'd0);
        step;
        @(negedge CLK);
        check_eq("t1_ren",   32'(u_if.ramREN), 32'd1);
        check_eq("t1_addr",  u_if.ramaddr, 32'h100);
        check_eq("t1_iwait_busy", 32'(u_if.iwait), 32'd3);
        step; u_if.ramstate = 2'd2; u_if.ramload = 32'h12345678;
        @(negedge CLK);
        check_eq("t1_iwait_done", 32'(u_if.iwait), 32'd2);
        check_eq("t1_iload0", u_if.iload[0], 32'h12345678);
        check_eq("t1_dwait", 32'(u_if.bus_dwait), 32'd1);
        step; u_if.iREN = 2'b00; u_if.ramstate = 2'd0;
        @(negedge CLK);
        check_eq("t1_idle_ren", 32'(u_if.ramREN), 32'd0);
        check_eq("t1_idle_iwait", 32'(u_if.iwait), 32'd3);

        // data write beats both fetches, then core 0, then core 1
        step; u_if.bus_dWEN = 1'b1; u_if.bus_daddr = 32'h200; u_if.bus_dstore = 32'hDEADBEEF;
        u_if.iREN = 2'b11; u_if.ramstate = 2'd1;
        @(negedge CLK);
        step;
        @(negedge CLK);
        check_eq("t2_wen",   32'(u_if.ramWEN), 32'd1);
        check_eq("t2_ren",   32'(u_if.ramREN), 32'd0);
        check_eq("t2_addr",  u_if.ramaddr, 32'h200);
        check_eq("t2_store", u_if.ramstore, 32'hDEADBEEF);
        check_eq("t2_iwait", 32'(u_if.iwait), 32'd3);
        step; u_if.ramstate = 2'd2;
        @(negedge CLK); check_eq("t2_dwait", 32'(u_if.bus_dwait), 32'd0);
        step; u_if.bus_dWEN = 1'b0; u_if.ramstate = 2'd1;
        @(negedge CLK); check_eq("t2_gap_en", 32'({u_if.ramREN, u_if.ramWEN}), 32'd0);
        step;
        @(negedge CLK);
        check_eq("t2_i0_ren",  32'(u_if.ramREN), 32'd1);
        check_eq("t2_i0_addr", u_if.ramaddr, 32'h100);
        check_eq("t2_i0_store", u_if.ramstore, 32'd0);
        step; u_if.ramstate = 2'd2;
        @(negedge CLK); check_eq("t2_i0_iwait", 32'(u_if.iwait), 32'd2);
        step; u_if.iREN = 2'b10; u_if.ramstate = 2'd1;
        @(negedge CLK); check_eq("t2_gap2_ren", 32'(u_if.ramREN), 32'd0);
        step;
        @(negedge CLK); check_eq("t2_i1_addr", u_if.ramaddr, 32'h300);
        step; u_if.ramstate = 2'd2;
        @(negedge CLK); check_eq("t2_i1_iwait", 32'(u_if.iwait), 32'd1);
        step; u_if.iREN = 2'b00; u_if.ramstate = 2'd0;

        // starvation: continuous data reads against a pending core 1 fetch
        step; u_if.bus_dREN = 1'b1; u_if.bus_daddr = 32'h400; u_if.iREN = 2'b10; u_if.ramstate = 2'd2;
        n_grant = 0;
        for (int c = 0; c < 40 && n_grant < 10; c++) begin
            @(negedge CLK);
            if (u_if.ramREN) begin
                g_addr[n_grant] = u_if.ramaddr;
                g_wait[n_grant] = {u_if.bus_dwait, u_if.iwait};
                n_grant++;
            end
        end
        check_eq("t3_grant_count", 32'(n_grant), 32'd10);
        for (int i = 0; i < n_grant; i++) begin
            check_eq($sformatf("t3_g%0d_addr", i), g_addr[i], (i % 5 == 4) ? 32'h300 : 32'h400);
            check_eq($sformatf("t3_g%0d_wait", i), 32'(g_wait[i]), (i % 5 == 4) ? 32'd5 : 32'd3);
        end
        step; u_if.bus_dREN = 1'b0; u_if.iREN = 2'b00; u_if.ramstate = 2'd0;

        // ERROR is retried, then the fetch is withdrawn
        step; u_if.iREN = 2'b01; u_if.ramstate = 2'd3;
        @(negedge CLK);
        for (int c = 0; c < 3; c++) begin
            step;
            @(negedge CLK);
            check_eq($sformatf("t4_err%0d_ren", c), 32'(u_if.ramREN), 32'd1);
            check_eq($sformatf("t4_err%0d_iwait", c), 32'(u_if.iwait), 32'd3);
        end
        step; u_if.iREN = 2'b00;
        @(negedge CLK);
        check_eq("t4_wd_ren",   32'(u_if.ramREN), 32'd0);
        check_eq("t4_wd_iwait", 32'(u_if.iwait), 32'd3);
        step; u_if.ramstate = 2'd0;
        @(negedge CLK);
        check_eq("t4_idle_iwait", 32'(u_if.iwait), 32'd3);

        // reset in the middle of a data write
        step; u_if.bus_dWEN = 1'b1; u_if.bus_daddr = 32'h500; u_if.bus_dstore = 32'h11112222;
        u_if.iREN = 2'b11; u_if.ramstate = 2'd1;
        @(negedge CLK);
        step;
        @(negedge CLK); check_eq("t5_pre_wen", 32'(u_if.ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check_eq("t5_rst_wen",   32'(u_if.ramWEN), 32'd0);
        check_eq("t5_rst_ren",   32'(u_if.ramREN), 32'd0);
        check_eq("t5_rst_dwait", 32'(u_if.bus_dwait), 32'd1);
        check_eq("t5_rst_iwait", 32'(u_if.iwait), 32'd3);
        check_eq("t5_rst_store", u_if.ramstore, 32'd0);
        step; nRST = 1'b1; u_if.bus_dWEN = 1'b0; u_if.bus_dREN = 1'b1;
        @(negedge CLK); check_eq("t5_idle_ren", 32'(u_if.ramREN), 32'd0);
        step;
        @(negedge CLK);
        check_eq("t5_d_en",   32'({u_if.ramREN, u_if.ramWEN}), 32'd2);
        check_eq("t5_d_addr", u_if.ramaddr, 32'h500);
        step; u_if.ramstate = 2'd2;
        @(negedge CLK); check_eq("t5_dwait", 32'(u_if.bus_dwait), 32'd0);
        step; u_if.bus_dREN = 1'b0; u_if.ramstate = 2'd1;
        @(negedge CLK);
        step;
        @(negedge CLK); check_eq("t5_rr_reset_addr", u_if.ramaddr, 32'h100);
        step; u_if.iREN = 2'b00; u_if.ramstate = 2'd0;
        @(negedge CLK);

        // read and write together: the write wins
        step; u_if.bus_dREN = 1'b1; u_if.bus_dWEN = 1'b1; u_if.bus_daddr = 32'h600;
        u_if.bus_dstore = 32'hCAFEF00D; u_if.ramstate = 2'd1;
        @(negedge CLK);
        step;
        @(negedge CLK);
        check_eq("t6_en",    32'({u_if.ramREN, u_if.ramWEN}), 32'd1);
        check_eq("t6_store", u_if.ramstore, 32'hCAFEF00D);
        check_eq("t6_addr",  u_if.ramaddr, 32'h600);
        step; u_if.ramstate = 2'd2; u_if.ramload = 32'hA5A5_0F0F;
        @(negedge CLK);
        check_eq("t6_dwait", 32'(u_if.bus_dwait), 32'd0);
        check_eq("t6_dload", u_if.bus_dload, 32'hA5A5_0F0F);
        step; u_if.bus_dREN = 1'b0; u_if.bus_dWEN = 1'b0; u_if.ramstate = 2'd0;
        @(negedge CLK); check_eq("t6_idle_wen", 32'(u_if.ramWEN), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port between the coherence bus controller's memory-side data requests and the two cores' instruction-cache fetches. Sits between the bus controller/icaches and the RAM model. It grants one requester at a time and holds the grant until the RAM completes. Data requests have priority. A starvation counter forces an instruction grant after a bounded run of data grants, and the two icaches alternate round-robin.

## Interface
- STARVE_LIMIT, 4, consecutive data grants tolerated while an instruction fetch is pending; legal range 1–15.
- CLK  in  1  clock; all state changes on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- bus_dREN  in  1  bus controller memory read request.
- bus_dWEN  in  1  bus controller memory write request; wins over bus_dREN if both are high.
- bus_daddr  in  32  data address.
- bus_dstore  in  32  write data.
- bus_dwait  out  1  low for exactly the completing cycle of a granted data access.
- bus_dload  out  32  equals ramload (pass-through).
- iREN  in  2  per-core instruction fetch request.
- iaddr  in  2x32  per-core fetch address.
- iwait  out  2  per-core; low only in the completing cycle of that core's grant.
- iload  out  2x32  each equals ramload.
- ramREN, ramWEN  out  1 each  RAM enables.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.

## Operation
- States: IDLE, DATA, INSTR0, INSTR1. Registers: state, rr (1 bit, next icache favoured), starve_cnt (4 bits).
- IDLE selection, evaluated in priority order:
  - If starve_cnt == STARVE_LIMIT and any iREN is high, go to INSTR.
  - Else if bus_dREN|bus_dWEN, go to DATA.
  - Else if any iREN, go to INSTR.
  - Else stay in IDLE.
- INSTR target: if both iREN are high, INSTR[rr]. Otherwise, the single requester.
- Data grant: starve_cnt increments (saturating at STARVE_LIMIT) when any iREN is high at the grant edge. Otherwise it is unchanged.
- Instruction grant: starve_cnt resets to 0 and rr becomes the other core. rr toggles only when both cores were requesting.
- DATA outputs: ramaddr=bus_daddr. If bus_dWEN: ramWEN=1, ramstore=bus_dstore, ramREN=0. Else: ramREN=1, ramstore=0.
- INSTRi outputs: ramREN=1, ramaddr=iaddr[i], ramWEN=0, ramstore=0.
- Completion: while granted, ramstate==ACCESS drives the granted wait low combinationally in that cycle. The next state is IDLE.
- ramstate FREE/BUSY/ERROR: wait stays high and the grant is held (ERROR is retried indefinitely).
- Withdrawal: if the granted requester drops its enables before ACCESS, return to IDLE at the next edge with no wait pulse. RAM enables fall with the requester's enables.
- IDLE outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0. All waits are 1.
- Non-granted requesters always see wait=1.

## Timing
- Reset (async, any state, including mid-access): state=IDLE, rr=0, starve_cnt=0. Outputs immediately take IDLE values: RAM enables 0, ramaddr/ramstore 0, bus_dwait=1, iwait=2'b11.
- Arbitration latency: a request high at edge n yields RAM enables asserted from cycle n+1.
- Completion: the wait-low cycle equals the ramstate==ACCESS cycle. The arbiter is in IDLE the following cycle. A back-to-back request is granted at the edge after that, so each transaction costs at least 1 IDLE cycle.
- Requesters hold address and data stable until their wait is low; the arbiter does not latch them.
- Simultaneous data and fetch requests with starve_cnt < STARVE_LIMIT: data is served first.

## Test plan
- Single fetch: iREN=01, iaddr[0]=0x100, ramstate=ACCESS on the 2nd granted cycle -> ramREN=1 and ramaddr=0x100 from cycle 1; iwait[0] low exactly one cycle; iload[0]=ramload; then IDLE.
- Data write priority: bus_dWEN=1 (addr 0x200, data 0xDEADBEEF) and iREN=11 arrive together -> DATA granted first with ramWEN=1 and ramstore=0xDEADBEEF; afterwards INSTR0, then INSTR1 (rr alternation).
- Starvation: bus_dREN held continuously, iREN=10, STARVE_LIMIT=4 -> exactly 4 data grants, then the 5th grant is INSTR1 and starve_cnt returns to 0.
- Withdrawal and ERROR: granted fetch with ramstate=ERROR for 3 cycles -> iwait stays high and the grant is held. Then iREN drops -> IDLE next edge, no wait pulse.
- Reset mid-access: assert nRST low during DATA with ramstate=BUSY -> ramWEN/ramREN=0 and bus_dwait=1 immediately. After release, the first grant goes to data if requested, with starve_cnt=0 and rr=0.
- Both dREN and dWEN high -> write performed (ramWEN=1, ramREN=0).
